// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg: shared state encoding and default sizes for the config-chain loader
package ccff_loader_pkg;
  localparam int NUM_CHAINS_DEF = 10;
  localparam int CHAIN_LEN_DEF = 1024;
  typedef enum logic [1:0] {IDLE, LOAD, READBACK, DONE} state_e;
endpackage

// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: shifts a valid/ready bitstream into parallel config chains, optionally rotating it back out as readback
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int NUM_CHAINS = NUM_CHAINS_DEF,
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  localparam int CNT_W = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  readback_en,
  input  logic [NUM_CHAINS-1:0] cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  prog_clock,
  output logic                  config_enable,
  output logic [NUM_CHAINS-1:0] ccff_head,
  input  logic [NUM_CHAINS-1:0] ccff_tail,
  output logic                  CFG_DONE,
  output logic [NUM_CHAINS-1:0] rb_data,
  output logic                  rb_valid,
  output logic                  busy
);
  state_e state_q, state_d;
  logic phase_q, phase_d, rb_en_q, rb_en_d, pc_q, pc_d, ce_q, ce_d, done_q, done_d, rbv_q, rbv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CHAINS-1:0] head_q, head_d, rbd_q, rbd_d;
  logic last;
  assign last = cnt_q == CNT_W'(CHAIN_LEN - 1);
  assign cfg_ready = state_q == LOAD && !phase_q;
  assign busy = state_q == LOAD || state_q == READBACK;
  assign prog_clock = pc_q;
  assign config_enable = ce_q;
  assign ccff_head = head_q;
  assign CFG_DONE = done_q;
  assign rb_data = rbd_q;
  assign rb_valid = rbv_q;
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d = cnt_q;
    rb_en_d = rb_en_q;
    pc_d = 1'b0;
    ce_d = ce_q;
    done_d = done_q;
    head_d = head_q;
    rbd_d = rbd_q;
    rbv_d = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = LOAD;
        phase_d = 1'b0;
        cnt_d = '0;
        ce_d = 1'b1;
        done_d = 1'b0;
        rb_en_d = readback_en;
      end
      default: if (phase_q) begin
        phase_d = 1'b0;
        cnt_d = last ? '0 : cnt_q + CNT_W'(1);
        if (last) begin
          state_d = (state_q == LOAD && rb_en_q) ? READBACK : DONE;
          ce_d = state_d == READBACK;
          done_d = state_d == DONE;
        end
      end else if (state_q == READBACK) begin
        head_d = ccff_tail;
        rbd_d = ccff_tail;
        rbv_d = 1'b1;
        phase_d = 1'b1;
        pc_d = 1'b1;
      end else if (cfg_valid) begin
        head_d = cfg_data;
        phase_d = 1'b1;
        pc_d = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      cnt_q <= '0;
      rb_en_q <= 1'b0;
      pc_q <= 1'b0;
      ce_q <= 1'b0;
      done_q <= 1'b0;
      head_q <= '0;
      rbd_q <= '0;
      rbv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q <= cnt_d;
      rb_en_q <= rb_en_d;
      pc_q <= pc_d;
      ce_q <= ce_d;
      done_q <= done_d;
      head_q <= head_d;
      rbd_q <= rbd_d;
      rbv_q <= rbv_d;
    end
  end
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb_ccff_bitstream_loader: randomized self-checking bench with a fabric chain model and transaction-level expectations
module tb_ccff_bitstream_loader;
  localparam int NC = 10;
  localparam int LEN = 1024;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, readback_en = 1'b0, cfg_valid = 1'b0;
  logic [NC-1:0] cfg_data = '0;
  logic cfg_ready, prog_clock, config_enable, CFG_DONE, rb_valid, busy;
  logic [NC-1:0] ccff_head, ccff_tail, rb_data;
  logic [NC-1:0] fab [LEN];
  logic [NC-1:0] wbuf [LEN];
  int gbuf [LEN];
  logic [NC-1:0] sent [$];
  logic [NC-1:0] rbq [$];
  int rb_cyc [$];
  int n_chk = 0, n_fail = 0, cyc = 0, rises = 0, rise_base = 0, first_hs = -1, done_cyc = -1;
  logic mon_en = 1'b0, pc_prev = 1'b0, hs_prev = 1'b0, done_prev = 1'b0;
  logic [NC-1:0] hs_data = '0;
  always #5 clk = ~clk;
  assign ccff_tail = fab[LEN-1];
  ccff_bitstream_loader #(.NUM_CHAINS(NC), .CHAIN_LEN(LEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .readback_en(readback_en),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .prog_clock(prog_clock), .config_enable(config_enable), .ccff_head(ccff_head),
    .ccff_tail(ccff_tail), .CFG_DONE(CFG_DONE), .rb_data(rb_data), .rb_valid(rb_valid),
    .busy(busy)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  initial begin
    foreach (fab[k]) fab[k] = '0;
    forever begin
      @(negedge clk);
      #4;
      cyc++;
      if (mon_en) begin
        chk("pc_model", prog_clock, hs_prev | rb_valid);
        chk("busy_ce", busy, config_enable);
        if (CFG_DONE) chk("done_quiet", {busy, prog_clock, rb_valid}, 3'b000);
        if (cfg_ready) chk("ready_ctx", {busy, prog_clock, rb_valid}, 3'b100);
        if (hs_prev) chk("head_load", ccff_head, hs_data);
        if (rb_valid) chk("rb_head", rb_data, ccff_head);
      end
      if (prog_clock === 1'b1 && !pc_prev) begin
        rises++;
        for (int k = LEN - 1; k > 0; k--) fab[k] = fab[k-1];
        fab[0] = ccff_head;
      end
      if (rb_valid === 1'b1) begin
        rbq.push_back(rb_data);
        rb_cyc.push_back(cyc);
      end
      if (CFG_DONE === 1'b1 && !done_prev && done_cyc < 0) done_cyc = cyc;
      pc_prev = prog_clock === 1'b1;
      done_prev = CFG_DONE === 1'b1;
      hs_prev = cfg_valid && cfg_ready === 1'b1 && rst_n;
      if (hs_prev) begin
        if (sent.size() == 0) first_hs = cyc;
        sent.push_back(cfg_data);
        hs_data = cfg_data;
      end
    end
  end
  task automatic clear_log();
    sent.delete();
    rbq.delete();
    rb_cyc.delete();
    first_hs = -1;
    done_cyc = -1;
    rise_base = rises;
  endtask
  task automatic send_word(input logic [NC-1:0] w);
    int t = 0;
    cfg_valid = 1'b1;
    cfg_data = w;
    while (!cfg_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("ready_timeout", 0, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask
  task automatic stall(input int g);
    int t = 0;
    while (!cfg_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < g; i++) begin
      chk("gap_idle", {cfg_ready, prog_clock}, 2'b10);
      @(negedge clk);
    end
  endtask
  task automatic run_op(input bit rb, input int bump_at);
    int gsum = 0, bad = 0, t = 0;
    clear_log();
    start = 1'b1;
    readback_en = rb;
    @(negedge clk);
    start = 1'b0;
    readback_en = 1'b0;
    chk("start_ack", {CFG_DONE, config_enable, busy}, 3'b011);
    for (int i = 0; i < LEN; i++) begin
      send_word(wbuf[i]);
      if (i == bump_at) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      if (gbuf[i] > 0) stall(gbuf[i]);
      gsum += gbuf[i];
    end
    while (!CFG_DONE && t < 4 * LEN + 10) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", CFG_DONE, 1);
    @(negedge clk);
    chk("done_time", done_cyc - first_hs, (rb ? 4 : 2) * LEN + gsum);
    chk("rises", rises - rise_base, (rb ? 2 : 1) * LEN);
    chk("accepted", sent.size(), LEN);
    for (int k = 0; k < LEN; k++) if (fab[LEN-1-k] !== wbuf[k]) bad++;
    chk("chain_contents", bad, 0);
    chk("rb_count", rbq.size(), rb ? LEN : 0);
    bad = 0;
    for (int k = 0; k < rbq.size() && k < LEN; k++) begin
      if (rbq[k] !== wbuf[k]) bad++;
      if (k > 0 && rb_cyc[k] - rb_cyc[k-1] != 2) bad++;
    end
    chk("rb_words", bad, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    chk("reset_ctrl", {prog_clock, config_enable, CFG_DONE, rb_valid, busy, cfg_ready}, 6'b0);
    chk("reset_data", {ccff_head, rb_data}, 0);
    clear_log();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_word(10'h001);
    send_word(10'h002);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midload_reset", {prog_clock, config_enable, CFG_DONE, rb_valid, busy, cfg_ready}, 6'b0);
    chk("midload_head", ccff_head, 0);
    rst_n = 1'b1;
    cfg_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_not_ready", {cfg_ready, busy}, 2'b00);
    end
    cfg_valid = 1'b0;
    chk("partial_shifts", rises - rise_base, 2);
    chk("partial_chain", {fab[1], fab[0]}, {10'h001, 10'h002});
    for (int i = 0; i < LEN; i++) begin
      wbuf[i] = NC'($urandom);
      gbuf[i] = 0;
    end
    wbuf[0] = 10'h001;
    wbuf[1] = 10'h002;
    wbuf[2] = 10'h003;
    wbuf[3] = 10'h000;
    run_op(1'b0, -1);
    chk("basic_latency", done_cyc - first_hs, 2048);
    chk("basic_deepest", {fab[LEN-1], fab[LEN-2], fab[LEN-3], fab[LEN-4]}, {10'h001, 10'h002, 10'h003, 10'h000});
    chk("basic_flags", {CFG_DONE, config_enable, prog_clock}, 3'b100);
    gbuf[1] = 5;
    run_op(1'b0, -1);
    chk("stall_latency", done_cyc - first_hs, 2053);
    gbuf[1] = 0;
    run_op(1'b1, -1);
    chk("rb_latency", done_cyc - first_hs, 4096);
    chk("rb_first", {rbq[0], rbq[1], rbq[2], rbq[3]}, {10'h001, 10'h002, 10'h003, 10'h000});
    chk("rb_spacing_lit", rb_cyc[1] - rb_cyc[0], 2);
    run_op(1'b0, 1);
    chk("bump_latency", done_cyc - first_hs, 2048);
    repeat (2) begin
      for (int i = 0; i < LEN; i++) begin
        wbuf[i] = NC'($urandom);
        gbuf[i] = (i < LEN - 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      end
      run_op(1'b1, -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
